// File: rtl/hm_rx_pkg.sv
// Shared types and constants for the host-memory reader receive path.
// States, completion header codes and the outstanding read tag.
package hm_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DROP,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } hm_rx_state_t;

  localparam logic [7:0] HM_CPLD_FMT_TYPE = 8'h4A;
  localparam logic [2:0] HM_CPL_SC        = 3'b000;
  localparam logic [7:0] HM_TAG_READ      = 8'h38;

  // A length field of zero encodes the 1024-DW maximum
  function automatic logic [10:0] hm_len_dw(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/hm_rx_realign.sv
// Packs the DW stream into 64-bit words through a one-DW hold register.
// The output word register is held until the consumer takes it.
module hm_rx_realign
  import hm_rx_pkg::*;
(
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic        clr,
  input  logic        push,
  input  logic        push_one,
  input  logic [31:0] dw_a,
  input  logic [31:0] dw_b,
  input  logic        flush,
  input  logic        ready,
  output logic [63:0] data,
  output logic        valid,
  output logic        hold_full
);

  logic [31:0] hold;
  logic [31:0] hold_nxt;
  logic        full_nxt;
  logic        emit;
  logic [63:0] word;
  logic        slot_free;

  assign slot_free = ~valid | ready;

  always_comb begin
    emit     = 1'b0;
    word     = 64'h0;
    hold_nxt = hold;
    full_nxt = hold_full;
    if (push) begin
      if (hold_full) begin
        emit = 1'b1;
        word = {hold, dw_a};
        if (push_one) full_nxt = 1'b0;
        else          hold_nxt = dw_b;
      end else if (push_one) begin
        hold_nxt = dw_a;
        full_nxt = 1'b1;
      end else begin
        emit = 1'b1;
        word = {dw_a, dw_b};
      end
    end else if (flush && hold_full && slot_free) begin
      emit     = 1'b1;
      word     = {hold, 32'h0};
      full_nxt = 1'b0;
    end
  end

  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) begin
      data      <= 64'h0;
      valid     <= 1'b0;
      hold      <= 32'h0;
      hold_full <= 1'b0;
    end else if (clr) begin
      valid     <= 1'b0;
      hold_full <= 1'b0;
    end else begin
      hold      <= hold_nxt;
      hold_full <= full_nxt;
      if (emit) begin
        data  <= word;
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hm_rx.sv
// Host-memory reader receive side: CplD filter, realign, end/error/timeout.
// Optional HM_RX_STATS_EN enables the completion/drop statistics counters.
module hm_rx
  import hm_rx_pkg::*;
#(
  parameter int          RX_DW       = 1024,
  parameter logic [15:0] TIMEOUT_MAX = 16'hffff,
  parameter logic [7:0]  HM_TAG      = HM_TAG_READ
) (
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic [63:0] trn_rd,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  output logic        trn_rdst_rdy_n,
  input  logic        trn_rerrfwd_n,
  input  logic        rx_start,
  input  logic [15:0] hm_req_id,
  output logic        rx_end,
  output logic        rx_err,
  output logic        timeout,
  output logic [63:0] hm_data,
  output logic        hm_data_valid,
  input  logic        hm_data_ready,
  output logic [31:0] stat_trn_cpt_rx,
  output logic [31:0] stat_trn_cpt_drop
);

  localparam logic [10:0] RX_DW_L = 11'(RX_DW);

  hm_rx_state_t state, nxt;
  logic [10:0] remaining, len_cnt, n_dw;
  logic [15:0] to_cnt;
  logic        first, sts_bad, err_ev;
  logic        beat, sof, eof, poison, is_cpld, id_ok;
  logic        in_data, hdr_go, hdr_drop, id_drop;
  logic        data_err, data_ok, one_dw, last_dw;
  logic        to_hit, flush_done, hold_full;
  logic        rl_clr, rl_push, rl_flush;

  assign beat     = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign sof      = ~trn_rsof_n;
  assign eof      = ~trn_reof_n;
  assign poison   = ~trn_rerrfwd_n;
  assign is_cpld  = trn_rd[63:56] == HM_CPLD_FMT_TYPE;
  assign id_ok    = (trn_rd[63:48] == hm_req_id) &&
                    (trn_rd[47:40] == HM_TAG);
  assign in_data  = (state == ST_DATA) && beat;
  assign hdr_go   = (state == ST_HDR) && beat && sof && is_cpld;
  assign hdr_drop = (state == ST_HDR) && beat && sof && !is_cpld;
  assign id_drop  = in_data && first && !id_ok;
  // Bad status is only an error once the tag proves the completion is ours
  assign data_err = in_data && !id_drop &&
                    (poison || (first && sts_bad));
  assign data_ok  = in_data && !id_drop && !data_err;
  assign one_dw   = first || (len_cnt < 11'd2);
  assign n_dw     = one_dw ? 11'd1 : 11'd2;
  assign last_dw  = data_ok && (remaining <= n_dw);
  assign to_hit   = (state != ST_IDLE) && (to_cnt == TIMEOUT_MAX);
  assign flush_done = !hold_full && (!hm_data_valid || hm_data_ready);

  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) state <= ST_IDLE;
    else              state <= nxt;
  end

  always_comb begin
    nxt    = state;
    err_ev = 1'b0;
    unique case (state)
      ST_IDLE:  if (rx_start) nxt = ST_HDR;
      ST_HDR: begin
        if (hdr_go)                nxt = ST_DATA;
        else if (hdr_drop && !eof) nxt = ST_DROP;
      end
      ST_DATA: begin
        if (id_drop) begin
          nxt = eof ? ST_HDR : ST_DROP;
        end else if (data_err) begin
          nxt    = eof ? ST_IDLE : ST_DRAIN;
          err_ev = eof;
        end else if (data_ok) begin
          if (last_dw)  nxt = ST_FLUSH;
          else if (eof) nxt = ST_HDR;
        end
      end
      ST_DROP:  if (beat && eof) nxt = ST_HDR;
      ST_DRAIN: begin
        if (beat && eof) begin
          nxt    = ST_IDLE;
          err_ev = 1'b1;
        end
      end
      ST_FLUSH: if (flush_done) nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
    if (to_hit) begin
      nxt    = ST_IDLE;
      err_ev = 1'b1;
    end
  end

  always_comb begin
    trn_rdst_rdy_n = 1'b1;
    if (trn_reset_n)
      trn_rdst_rdy_n = (state == ST_IDLE) ? 1'b0 :
                       ~(hm_data_ready | ~hm_data_valid);
    rx_end   = (state == ST_DONE);
    rl_clr   = ((state == ST_IDLE) && rx_start) || data_err || to_hit;
    rl_push  = data_ok;
    rl_flush = (state == ST_FLUSH);
  end

  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) begin
      remaining <= 11'd0;
      len_cnt   <= 11'd0;
      first     <= 1'b0;
      sts_bad   <= 1'b0;
      to_cnt    <= 16'd0;
      rx_err    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      rx_err  <= err_ev;
      timeout <= to_hit;
      if ((state == ST_IDLE) || beat) to_cnt <= 16'd0;
      else if (!to_hit)               to_cnt <= to_cnt + 16'd1;
      if ((state == ST_IDLE) && rx_start) remaining <= RX_DW_L;
      else if (data_ok)                   remaining <= remaining - n_dw;
      if (hdr_go) begin
        len_cnt <= hm_len_dw(trn_rd[41:32]);
        sts_bad <= trn_rd[15:13] != HM_CPL_SC;
        first   <= 1'b1;
      end else if (in_data) begin
        first <= 1'b0;
        if (data_ok) len_cnt <= len_cnt - n_dw;
      end
    end
  end

`ifdef HM_RX_STATS_EN
  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) begin
      stat_trn_cpt_rx   <= 32'h0;
      stat_trn_cpt_drop <= 32'h0;
    end else begin
      if (data_ok && first)    stat_trn_cpt_rx   <= stat_trn_cpt_rx + 32'd1;
      if (hdr_drop || id_drop) stat_trn_cpt_drop <= stat_trn_cpt_drop + 32'd1;
    end
  end
`else
  assign stat_trn_cpt_rx   = 32'h0;
  assign stat_trn_cpt_drop = 32'h0;
`endif

  hm_rx_realign u_realign (
    .trn_clk     (trn_clk),
    .trn_reset_n (trn_reset_n),
    .clr         (rl_clr),
    .push        (rl_push),
    .push_one    (one_dw),
    .dw_a        (first ? trn_rd[31:0] : trn_rd[63:32]),
    .dw_b        (trn_rd[31:0]),
    .flush       (rl_flush),
    .ready       (hm_data_ready),
    .data        (hm_data),
    .valid       (hm_data_valid),
    .hold_full   (hold_full)
  );

endmodule

// File: tb/tb_hm_rx.sv
// Scoreboard bench for hm_rx with RX_DW=8: split/dropped TLPs, stalls,
// UR error and timeout.
module tb_hm_rx;

  localparam logic [15:0] REQ_ID = 16'h0208;

  logic        trn_clk;
  logic        trn_reset_n;
  logic [63:0] trn_rd;
  logic        trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n;
  logic        trn_rdst_rdy_n, trn_rerrfwd_n;
  logic        rx_start;
  logic [15:0] hm_req_id;
  logic        rx_end, rx_err, timeout;
  logic [63:0] hm_data;
  logic        hm_data_valid, hm_data_ready;
  logic [31:0] stat_trn_cpt_rx, stat_trn_cpt_drop;

  hm_rx #(.RX_DW(8)) dut (
    .trn_clk           (trn_clk),
    .trn_reset_n       (trn_reset_n),
    .trn_rd            (trn_rd),
    .trn_rsof_n        (trn_rsof_n),
    .trn_reof_n        (trn_reof_n),
    .trn_rsrc_rdy_n    (trn_rsrc_rdy_n),
    .trn_rdst_rdy_n    (trn_rdst_rdy_n),
    .trn_rerrfwd_n     (trn_rerrfwd_n),
    .rx_start          (rx_start),
    .hm_req_id         (hm_req_id),
    .rx_end            (rx_end),
    .rx_err            (rx_err),
    .timeout           (timeout),
    .hm_data           (hm_data),
    .hm_data_valid     (hm_data_valid),
    .hm_data_ready     (hm_data_ready),
    .stat_trn_cpt_rx   (stat_trn_cpt_rx),
    .stat_trn_cpt_drop (stat_trn_cpt_drop)
  );

  initial begin
    trn_clk = 1'b0;
    forever #5 trn_clk = ~trn_clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_acc_cyc = 0;
  int n_end = 0;
  int n_err = 0;
  int exp_rx = 0;
  int exp_drop = 0;
  logic [63:0] exp_q[$];

  always @(posedge trn_clk) cyc <= cyc + 1;

  always @(negedge trn_clk) begin
    if (trn_reset_n) begin
      if (hm_data_valid && hm_data_ready) begin
        logic [63:0] e;
        checks++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_extra got %h expected none", hm_data);
        end else begin
          e = exp_q.pop_front();
          if (hm_data !== e) begin
            errors++;
            $display("FAIL word got %h expected %h", hm_data, e);
          end
        end
      end
      if (rx_end) n_end++;
      if (rx_err) n_err++;
    end
  end

  function automatic logic [31:0] stat_exp(input int v);
`ifdef HM_RX_STATS_EN
    return 32'(v);
`else
    return (v == -1) ? 32'h1 : 32'h0;
`endif
  endfunction

  task automatic push_words(input int base);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({32'(base + 2 * i), 32'(base + 2 * i + 1)});
  endtask

  task automatic pulse_start();
    @(posedge trn_clk);
    #1 rx_start = 1'b1;
    @(posedge trn_clk);
    #1 rx_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_beat(input logic [63:0] d, input bit sof,
                           input bit eof);
    int n;
    trn_rd = d;
    trn_rsof_n = ~sof;
    trn_reof_n = ~eof;
    trn_rsrc_rdy_n = 1'b0;
    n = 0;
    forever begin
      @(negedge trn_clk);
      if (!trn_rdst_rdy_n) break;
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL beat_accept rdst_rdy_n=%b expected 0", trn_rdst_rdy_n);
        break;
      end
    end
    @(posedge trn_clk);
    #1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n = 1'b1;
    trn_reof_n = 1'b1;
  endtask

  task automatic send_tlp(input logic [31:0] dw[$]);
    int nb;
    nb = (dw.size() + 1) / 2;
    for (int i = 0; i < nb; i++)
      send_beat({dw[2 * i], (2 * i + 1 < dw.size()) ? dw[2 * i + 1] : 32'h0},
                i == 0, i == nb - 1);
  endtask

  task automatic send_cpld(input int len, input logic [7:0] tag,
                           input logic [2:0] sts, input int base);
    logic [31:0] dw[$];
    dw.push_back({8'h4A, 14'h0, 10'(len)});
    dw.push_back({16'h0100, sts, 1'b0, 12'(len * 4)});
    dw.push_back({REQ_ID, tag, 8'h00});
    for (int i = 0; i < len; i++) dw.push_back(32'(base + i));
    send_tlp(dw);
  endtask

  // which: 0 rx_end, 1 rx_err, 2 timeout
  task automatic wait_pulse(input int which, input int bound,
                            output bit found, output int at);
    found = 1'b0;
    at = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge trn_clk);
      #1;
      if ((which == 0 && rx_end) || (which == 1 && rx_err) ||
          (which == 2 && timeout)) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    trn_reset_n = 1'b0;
    repeat (3) @(posedge trn_clk);
    @(negedge trn_clk);
    checks++;
    if ({trn_rdst_rdy_n, hm_data_valid, rx_end, rx_err, timeout} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctl got rdy_n/v/end/err/to=%b expected 10000",
               {trn_rdst_rdy_n, hm_data_valid, rx_end, rx_err, timeout});
    end
    checks++;
    if (hm_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h expected 0", hm_data);
    end
    checks++;
    if (stat_trn_cpt_rx !== 32'h0 || stat_trn_cpt_drop !== 32'h0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d expected 0/0",
               stat_trn_cpt_rx, stat_trn_cpt_drop);
    end
    @(posedge trn_clk);
    #1 trn_reset_n = 1'b1;
    @(negedge trn_clk);
    checks++;
    if (trn_rdst_rdy_n !== 1'b0) begin
      errors++;
      $display("FAIL idle_rdy got %b expected 0", trn_rdst_rdy_n);
    end
  endtask

  task automatic finish_transfer(input string name);
    bit found;
    int at;
    wait_pulse(0, 200, found, at);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_end got no rx_end expected pulse", name);
    end else begin
      checks++;
      if (at !== last_acc_cyc + 1) begin
        errors++;
        $display("FAIL %s_end_lat got cycle %0d expected %0d", name, at,
                 last_acc_cyc + 1);
      end
      @(negedge trn_clk);
      checks++;
      if (rx_end !== 1'b0) begin
        errors++;
        $display("FAIL %s_end_pulse got %b expected 0", name, rx_end);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_words got %0d left expected 0", name, exp_q.size());
    end
    checks++;
    if (stat_trn_cpt_rx !== stat_exp(exp_rx) ||
        stat_trn_cpt_drop !== stat_exp(exp_drop)) begin
      errors++;
      $display("FAIL %s_stats got %0d/%0d expected %0d/%0d", name,
               stat_trn_cpt_rx, stat_trn_cpt_drop, stat_exp(exp_rx),
               stat_exp(exp_drop));
    end
  endtask

  task automatic test_single_cpl();
    push_words(0);
    exp_rx++;
    pulse_start();
    send_cpld(8, 8'h38, 3'b000, 0);
    finish_transfer("single");
  endtask

  task automatic test_split_cpl();
    push_words(0);
    exp_rx += 2;
    pulse_start();
    send_cpld(3, 8'h38, 3'b000, 0);
    send_cpld(5, 8'h38, 3'b000, 3);
    finish_transfer("split");
  endtask

  task automatic test_drop();
    logic [31:0] mwr[$];
    mwr = '{32'h4000_0002, 32'h0208_00ff, 32'h1000_0000,
            32'hdead_0001, 32'hdead_0002};
    push_words(16);
    exp_rx += 2;
    exp_drop += 2;
    pulse_start();
    send_cpld(3, 8'h38, 3'b000, 16);
    send_tlp(mwr);
    send_cpld(5, 8'h11, 3'b000, 100);
    send_cpld(5, 8'h38, 3'b000, 19);
    finish_transfer("drop");
  endtask

  task automatic test_back_pressure();
    int stalled;
    stalled = 0;
    push_words(40);
    exp_rx++;
    pulse_start();
    fork
      send_cpld(8, 8'h38, 3'b000, 40);
      begin
        repeat (4) @(posedge trn_clk);
        #1 hm_data_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge trn_clk);
          if (hm_data_valid) begin
            stalled++;
            checks++;
            if (trn_rdst_rdy_n !== 1'b1) begin
              errors++;
              $display("FAIL stall_rdy got %b expected 1", trn_rdst_rdy_n);
            end
          end
        end
        @(posedge trn_clk);
        #1 hm_data_ready = 1'b1;
      end
    join
    checks++;
    if (stalled < 9) begin
      errors++;
      $display("FAIL stall_cycles got %0d expected >= 9", stalled);
    end
    finish_transfer("stall");
  endtask

  task automatic test_ur_error();
    bit found;
    int at, end0, err0;
    end0 = n_end;
    err0 = n_err;
    pulse_start();
    send_cpld(4, 8'h38, 3'b001, 200);
    wait_pulse(1, 50, found, at);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ur_err got no rx_err expected pulse");
    end
    checks++;
    if (timeout !== 1'b0 || hm_data_valid !== 1'b0 || trn_rdst_rdy_n !== 1'b0) begin
      errors++;
      $display("FAIL ur_state got to/v/rdy_n=%b expected 000",
               {timeout, hm_data_valid, trn_rdst_rdy_n});
    end
    repeat (3) @(negedge trn_clk);
    #1;
    checks++;
    if (n_end !== end0 || n_err !== err0 + 1) begin
      errors++;
      $display("FAIL ur_pulses got end/err %0d/%0d expected %0d/%0d",
               n_end - end0, n_err - err0, 0, 1);
    end
    push_words(60);
    exp_rx++;
    pulse_start();
    send_cpld(8, 8'h38, 3'b000, 60);
    finish_transfer("after_ur");
  endtask

  task automatic test_timeout();
    bit found;
    int at;
    pulse_start();
    wait_pulse(2, 70000, found, at);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL timeout got no pulse expected pulse");
    end else begin
      checks++;
      if (rx_err !== 1'b1 || hm_data_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_flags got err/v=%b%b expected 10",
                 rx_err, hm_data_valid);
      end
      checks++;
      if (at - start_cyc !== 65536) begin
        errors++;
        $display("FAIL timeout_cycles got %0d expected 65536", at - start_cyc);
      end
      @(negedge trn_clk);
      checks++;
      if (timeout !== 1'b0 || rx_err !== 1'b0 || trn_rdst_rdy_n !== 1'b0) begin
        errors++;
        $display("FAIL timeout_after got to/err/rdy_n=%b expected 000",
                 {timeout, rx_err, trn_rdst_rdy_n});
      end
    end
  endtask

  initial begin
    trn_reset_n = 1'b0;
    trn_rd = 64'h0;
    trn_rsof_n = 1'b1;
    trn_reof_n = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rerrfwd_n = 1'b1;
    rx_start = 1'b0;
    hm_req_id = REQ_ID;
    hm_data_ready = 1'b1;
    test_reset();
    test_single_cpl();
    test_split_cpl();
    test_drop();
    test_back_pressure();
    test_ur_error();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
